uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one `uart_tx` transmitter between `NUM_REQ` byte producers. It accepts one byte per grant and drives the transmitter's `tx_start`/`data` handshake. It then waits for `tx_done` and reports per-requester completion. It sits between the CPU-side byte sources (debug, console, status) and the `uart_tx` instance.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `clk_freq`, 1000000: system clock in Hz; must match the `uart_tx` instance.
- `baud_rate`, 9600: baud rate; must match the `uart_tx` instance.
- `clk` in 1: system clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req` in `NUM_REQ`: per-requester request level; held until granted.
- `req_data` in `8*NUM_REQ`: byte of requester i in bits `[8i+7:8i]`.
- `gnt` out `NUM_REQ`: one-hot, 1-cycle pulse; the byte has been latched.
- `done` out `NUM_REQ`: one-hot, 1-cycle pulse; the owner's byte finished (stop bit sent).
- `err` out 1: 1-cycle pulse on watchdog abort; constant 0 when the watchdog is compiled out.
- `busy` out 1: high from grant until return to IDLE.
- `owner` out `$clog2(NUM_REQ)`: index of the current or last granted requester.
- `tx_start` out 1: to `uart_tx.tx_start`.
- `tx_data` out 8: to `uart_tx.data`.
- `tx_busy` in 1: from `uart_tx.tx_busy`.
- `tx_done` in 1: from `uart_tx.tx_done`, a 1-cycle pulse at the end of the stop bit.

## Operation
- The FSM has three states: IDLE, START and WAIT_DONE.
- **IDLE**
  - If `|req` and `!tx_busy`, pick the winner: the first set `req` bit at or after `ptr`, scanning upward with wrap.
  - Register `gnt[w]=1`, `tx_start=1`, `tx_data=req_data[w]`, `owner=w`, `busy=1`.
  - Next state is START.
- **START** (one cycle, with `gnt` and `tx_start` high)
  - Next state is WAIT_DONE; `gnt` and `tx_start` drop to 0.
- **WAIT_DONE**
  - `tx_data` and `owner` are held stable.
  - On `tx_done`: pulse `done[owner]`, set `ptr = owner+1` mod `NUM_REQ`, clear `busy`, go to IDLE.
- **Reset** (synchronous, from any state, including mid-frame):
  - State IDLE, `ptr=0`.
  - `gnt`, `done`, `err`, `busy`, `tx_start` and `tx_data` all 0.
  - `owner=0`.
- **Requester rule:** deassert `req`, or present a new byte, in the cycle after `gnt`. `req` is ignored outside IDLE.
- **Request withdrawn:** a `req` dropped before grant is never granted; there is no latched state per requester.
- **`tx_busy` high in IDLE** (external use or reset skew): no grant until it falls.
- **`tx_done` in IDLE or START:** ignored.
- **Fairness:** every continuously asserted requester is granted within `NUM_REQ` frames.

## Timing
- `req` high at edge k (FSM in IDLE, `tx_busy` low): `gnt` and `tx_start` are high in cycle k+1, for exactly one cycle.
- `tx_done` at edge m: `done[owner]` is high in cycle m+1, and FSM is in IDLE in cycle m+1.
- The earliest next `tx_start` is cycle m+2, giving 2 idle cycles between frames at the arbiter.
- Frame time is set by `uart_tx`: 10 × `clk_freq/baud_rate` cycles (1040 at the defaults).
- Every output is registered; there are no combinational input-to-output paths.

## Configuration
- The macro is `UART_TX_ARB_WATCHDOG_EN`.
- **Defined:**
  - A counter runs in WAIT_DONE.
  - If it reaches `WD_LIMIT = 12*(clk_freq/baud_rate)` cycles (1248 at the defaults) without `tx_done`, pulse `err` for 1 cycle.
  - `done` does not pulse for an aborted byte.
  - `ptr` advances past the owner and the FSM returns to IDLE.
  - The counter clears on entry to WAIT_DONE and on reset.
- **Undefined:**
  - No counter; WAIT_DONE waits indefinitely.
  - `err` is tied to 0.

## Structure
- The shared package is `uart_arb_pkg`. It contains:
  - the state enum (IDLE, START, WAIT_DONE);
  - the `clks_per_bit` function of `clk_freq`/`baud_rate`;
  - the `WD_LIMIT` constant;
  - the max `NUM_REQ` constant.
- The only sub-module is `uart_rr_pick`: combinational wrap-around priority pick over `req` from `ptr`, returning `valid` and the winner index.
- The FSM, pointer, datapath latch and watchdog stay in `uart_tx_arbiter`.

## Test plan
- **Single request:**
  - Stimulus: reset, then `req=4'b0100`, `req_data[23:16]=8'hA5`.
  - Response: `gnt=4'b0100` and `tx_start` high 1 cycle later; `tx_data=8'hA5`; `owner=2`.
  - On `tx_done`, `done=4'b0100` follows 1 cycle later.
- **Round-robin:**
  - Stimulus: `req=4'b1111` held continuously, data 8'h10/8'h21/8'h32/8'h43.
  - Response: grant order 0,1,2,3,0.
  - Each `tx_start` comes 2 cycles after the previous `tx_done`.
- **Wrap and skip:**
  - Stimulus: after granting 3, `req=4'b0101`.
  - Response: next grant is 0, then 2; 1 and 3 are never granted.
- **`tx_busy` blocking:**
  - Stimulus: force `tx_busy=1` with `req=4'b0001` for 50 cycles, then release.
  - Response: no `gnt` during the 50 cycles; `gnt` appears 1 cycle after release.
- **Reset mid-frame:**
  - Stimulus: assert `reset` in WAIT_DONE.
  - Response: next cycle all outputs are 0 and `ptr=0`.
  - With `req=4'b1010`, requester 1 wins next.
- **Watchdog** (macro defined):
  - Stimulus: suppress `tx_done`.
  - Response: `err` pulses 1248 cycles after entering WAIT_DONE; no `done`; FSM returns to IDLE.
  - With the macro undefined, `err` stays 0 and `busy` stays 1.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and timing helpers for the uart_tx round-robin arbiter.
// Watchdog timing lives here; it is only used when UART_TX_ARB_WATCHDOG_EN is defined.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_t;

  localparam int MAX_NUM_REQ       = 8;
  localparam int DEFAULT_CLK_FREQ  = 1000000;
  localparam int DEFAULT_BAUD_RATE = 9600;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // Abort threshold: 12 bit times, comfortably above one 10-bit frame.
  localparam int WD_LIMIT = 12 * clks_per_bit(DEFAULT_CLK_FREQ, DEFAULT_BAUD_RATE);

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational wrap-around priority pick: first set req bit at or after ptr.
module uart_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic                       valid,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest candidate down so the nearest one to ptr wins.
  always_comb begin
    idx  = ptr;
    cand = ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (req[cand]) idx = cand;
    end
  end

  assign valid = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer sharing one uart_tx between NUM_REQ byte producers.
// Optional watchdog abort of a stuck frame: define UART_TX_ARB_WATCHDOG_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int clk_freq  = 1000000,
  parameter int baud_rate = 9600
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         done,
  output logic                       err,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic                       tx_busy,
  input  logic                       tx_done,
  output arb_state_t                 state
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > MAX_NUM_REQ || clks_per_bit(clk_freq, baud_rate) < 1) begin : g_bad_cfg
    $error("uart_tx_arbiter: unsupported NUM_REQ or clock/baud configuration");
  end

  arb_state_t         state_q, state_next;
  logic [IDX_W-1:0]   ptr_q, ptr_next, owner_next, pick_idx, ptr_after;
  logic [NUM_REQ-1:0] gnt_next, done_next;
  logic               err_next, busy_next, tx_start_next, pick_valid;
  logic [7:0]         tx_data_next, pick_data;

  uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    pick_data = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == pick_idx) pick_data = req_data[8*i +: 8];
    end
  end

  assign ptr_after = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);

`ifdef UART_TX_ARB_WATCHDOG_EN
  localparam int WD_CYCLES = 12 * clks_per_bit(clk_freq, baud_rate);
  localparam int WD_CNT_W  = $clog2(WD_CYCLES + 1);

  logic [WD_CNT_W-1:0] wd_cnt_q;
  logic                wd_expired;

  // Cleared everywhere outside WAIT_DONE, so it restarts on each entry.
  always_ff @(posedge clk) begin
    if (reset || state_q != WAIT_DONE) wd_cnt_q <= '0;
    else                               wd_cnt_q <= wd_cnt_q + WD_CNT_W'(1);
  end

  assign wd_expired = (wd_cnt_q == WD_CNT_W'(WD_CYCLES - 1));
`endif

  // gnt: byte latched this cycle. tx_start/tx_done: start pulse to uart_tx, end-of-stop-bit pulse back.
  always_comb begin
    state_next    = state_q;
    ptr_next      = ptr_q;
    gnt_next      = '0;
    done_next     = '0;
    err_next      = 1'b0;
    busy_next     = busy;
    owner_next    = owner;
    tx_start_next = 1'b0;
    tx_data_next  = tx_data;
    unique case (state_q)
      IDLE: begin
        if (pick_valid && !tx_busy) begin
          gnt_next[pick_idx] = 1'b1;
          tx_start_next      = 1'b1;
          tx_data_next       = pick_data;
          owner_next         = pick_idx;
          busy_next          = 1'b1;
          state_next         = START;
        end
      end
      START: state_next = WAIT_DONE;
      WAIT_DONE: begin
        if (tx_done) begin
          done_next[owner] = 1'b1;
          ptr_next         = ptr_after;
          busy_next        = 1'b0;
          state_next       = IDLE;
        end
`ifdef UART_TX_ARB_WATCHDOG_EN
        else if (wd_expired) begin
          err_next   = 1'b1;
          ptr_next   = ptr_after;
          busy_next  = 1'b0;
          state_next = IDLE;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt      <= '0;
      done     <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
      owner    <= '0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      state_q  <= state_next;
      ptr_q    <= ptr_next;
      gnt      <= gnt_next;
      done     <= done_next;
      err      <= err_next;
      busy     <= busy_next;
      owner    <= owner_next;
      tx_start <= tx_start_next;
      tx_data  <= tx_data_next;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized self-checking bench for uart_tx_arbiter with a transaction-level round-robin model.
// Expectations for the watchdog follow UART_TX_ARB_WATCHDOG_EN.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req;
  logic [8*N-1:0]   req_data;
  logic [N-1:0]     gnt, done;
  logic             err, busy, tx_start, tx_busy, tx_done;
  logic [IW-1:0]    owner;
  logic [7:0]       tx_data;
  arb_state_t       state;

  int               checks = 0;
  int               failures = 0;
  int               model_ptr = 0;
  logic [7:0]       bytes_v[N];
  logic [IW-1:0]    exp_q[$];

  uart_tx_arbiter #(.NUM_REQ(N), .clk_freq(1000000), .baud_rate(9600)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .gnt(gnt), .done(done), .err(err), .busy(busy), .owner(owner),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference arbitration: first requester at or after the pointer, wrapping.
  function automatic int model_pick(input logic [N-1:0] r);
    for (int i = 0; i < N; i++) begin
      if (r[(model_ptr + i) % N]) return (model_ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic load_bytes();
    for (int i = 0; i < N; i++) req_data[8*i +: 8] = bytes_v[i];
  endtask

  task automatic random_bytes();
    for (int i = 0; i < N; i++) bytes_v[i] = 8'($urandom_range(0, 255));
    load_bytes();
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; tx_busy = 1'b0; tx_done = 1'b0;
    @(negedge clk); @(negedge clk);
    check_eq("rst_gnt", 32'(gnt), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_err", 32'(err), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_tx_start", 32'(tx_start), 0);
    check_eq("rst_tx_data", 32'(tx_data), 0);
    check_eq("rst_owner", 32'(owner), 0);
    check_eq("rst_state", 32'(state), 32'(IDLE));
    reset = 1'b0;
    model_ptr = 0;
    exp_q.delete();
  endtask

  // Entered at a negedge with the DUT idle and tx_busy low; returns at the negedge showing done.
  task automatic run_frame(input logic [N-1:0] r, input int blen, input bit drop, input bit early_done);
    int w;
    logic [7:0] exp_data;
    logic [N-1:0] onehot;
    logic [IW-1:0] exp_owner;
    w = model_pick(r);
    req = r;
    if (w < 0) begin
      @(negedge clk);
      check_eq("idle_gnt", 32'(gnt), 0);
      return;
    end
    exp_data = bytes_v[w];
    exp_q.push_back(IW'(w));
    onehot = '0; onehot[w] = 1'b1;
    @(negedge clk);
    check_eq("gnt", 32'(gnt), 32'(onehot));
    check_eq("tx_start", 32'(tx_start), 1);
    check_eq("tx_data", 32'(tx_data), 32'(exp_data));
    check_eq("owner", 32'(owner), 32'(w));
    check_eq("busy_on", 32'(busy), 1);
    if (drop) begin
      req = '0;
      random_bytes();
    end
    tx_busy = 1'b1;
    if (early_done) tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check_eq("gnt_drop", 32'(gnt), 0);
    check_eq("tx_start_drop", 32'(tx_start), 0);
    check_eq("state_wait", 32'(state), 32'(WAIT_DONE));
    repeat (blen) @(negedge clk);
    check_eq("tx_data_hold", 32'(tx_data), 32'(exp_data));
    check_eq("owner_hold", 32'(owner), 32'(w));
    check_eq("busy_hold", 32'(busy), 1);
    check_eq("done_early", 32'(done), 0);
    tx_busy = 1'b0; tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    exp_owner = exp_q.pop_front();
    onehot = '0; onehot[exp_owner] = 1'b1;
    check_eq("done", 32'(done), 32'(onehot));
    check_eq("busy_off", 32'(busy), 0);
    check_eq("state_idle", 32'(state), 32'(IDLE));
    model_ptr = (int'(exp_owner) + 1) % N;
  endtask

  initial begin
    int cnt;
    int w;
    reset = 1'b1; req = '0; req_data = '0; tx_busy = 1'b0; tx_done = 1'b0;
    do_reset();

    // Single request from requester 2.
    random_bytes();
    bytes_v[2] = 8'hA5; load_bytes();
    run_frame(4'b0100, 10, 1'b1, 1'b0);

    // tx_done while idle must not produce done.
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    @(negedge clk);
    check_eq("idle_tx_done", 32'(done), 0);

    // Round-robin with all requesters held, then wrap and skip.
    do_reset();
    bytes_v[0] = 8'h10; bytes_v[1] = 8'h21; bytes_v[2] = 8'h32; bytes_v[3] = 8'h43;
    load_bytes();
    for (int i = 0; i < 5; i++) run_frame(4'b1111, $urandom_range(2, 20), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) run_frame(4'b1110, $urandom_range(2, 20), 1'b0, 1'b0);
    check_eq("wrap_owner_3", 32'(owner), 3);
    for (int i = 0; i < 2; i++) run_frame(4'b0101, $urandom_range(2, 20), 1'b0, 1'b0);
    check_eq("skip_owner_2", 32'(owner), 2);

    // tx_busy blocks grants, release grants on the next cycle.
    req = 4'b0001; tx_busy = 1'b1;
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (gnt != '0) cnt++;
    end
    check_eq("busy_block", 32'(cnt), 0);
    tx_busy = 1'b0;
    run_frame(4'b0001, 5, 1'b1, 1'b0);

    // Request withdrawn before grant is never granted.
    req = 4'b0100; tx_busy = 1'b1;
    @(negedge clk);
    req = '0; tx_busy = 1'b0;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (gnt != '0) cnt++;
    end
    check_eq("withdrawn", 32'(cnt), 0);

    // Randomized traffic.
    for (int i = 0; i < 25; i++) begin
      random_bytes();
      run_frame(N'($urandom_range(0, 15)), $urandom_range(1, 20),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    req = '0;
    @(negedge clk);

    // Reset in the middle of a frame.
    random_bytes();
    req = 4'b0100;
    @(negedge clk);
    req = '0; tx_busy = 1'b1;
    @(negedge clk);
    repeat (5) @(negedge clk);
    check_eq("mid_state", 32'(state), 32'(WAIT_DONE));
    do_reset();
    run_frame(4'b1010, 8, 1'b1, 1'b0);

    // tx_done suppressed.
    random_bytes();
    w = model_pick(4'b0001);
    req = 4'b0001;
    @(negedge clk);
    check_eq("wd_gnt", 32'(gnt), 1);
    req = '0; tx_busy = 1'b1;
    @(negedge clk);
`ifdef UART_TX_ARB_WATCHDOG_EN
    cnt = 0;
    while (err !== 1'b1 && cnt < WD_LIMIT + 50) begin
      @(negedge clk);
      cnt++;
    end
    check_eq("wd_latency", 32'(cnt), 32'(WD_LIMIT));
    check_eq("wd_no_done", 32'(done), 0);
    check_eq("wd_state", 32'(state), 32'(IDLE));
    check_eq("wd_busy", 32'(busy), 0);
    @(negedge clk);
    check_eq("wd_err_pulse", 32'(err), 0);
    tx_busy = 1'b0;
    model_ptr = (w + 1) % N;
`else
    cnt = 0;
    repeat (WD_LIMIT + 50) begin
      @(negedge clk);
      if (err) cnt++;
    end
    check_eq("no_wd_err", 32'(cnt), 0);
    check_eq("no_wd_busy", 32'(busy), 1);
    check_eq("no_wd_state", 32'(state), 32'(WAIT_DONE));
    tx_busy = 1'b0; tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check_eq("no_wd_done", 32'(done), 1);
    model_ptr = (w + 1) % N;
`endif
    random_bytes();
    run_frame(4'b0011, 6, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
